hilo_muldiv_ctrl: RTL and testbench



---
 rtl/hilo_muldiv_ctrl.sv | 153 +++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer beside EX: owns HI/LO, runs 32-step iterative multiply/divide,
// and stalls the pipeline until the result is committed and EX advances.
module hilo_muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_sel,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        ex_hold,
    input  logic        cancel,
    output logic        stallreq,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH, DONE} state_t;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic [63:0] acc;        // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] mcand;      // multiplicand or divisor magnitude
    logic        mode_div;
    logic        sign_q;
    logic        sign_r;

    logic        is_muldiv, signed_op, div_op, accept, div_zero;
    logic [31:0] abs1, abs2;
    logic [32:0] mul_sum, div_trial;
    logic [63:0] acc_step, prod_fix;
    logic [31:0] res_hi, res_lo;

    assign is_muldiv = op_valid && (op_sel == OP_MULT || op_sel == OP_MULTU ||
                                    op_sel == OP_DIV  || op_sel == OP_DIVU);
    assign signed_op = (op_sel == OP_MULT) || (op_sel == OP_DIV);
    assign div_op    = (op_sel == OP_DIV)  || (op_sel == OP_DIVU);
    assign accept    = (state == IDLE) && is_muldiv && !cancel;
    assign div_zero  = div_op && (src2 == 32'd0);

    assign abs1 = (signed_op && src1[31]) ? -src1 : src1;
    assign abs2 = (signed_op && src2[31]) ? -src2 : src2;

    // Multiply adds into the upper half then shifts right; divide shifts left
    // and keeps the trial subtraction only when it does not borrow.
    assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
    assign div_trial = acc[63:31] - {1'b0, mcand};

    always_comb begin
        acc_step = acc;
        if (mode_div) begin
            if (!div_trial[32]) acc_step = {div_trial[31:0], acc[30:0], 1'b1};
            else                acc_step = {acc[62:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc[31:1]};
        end
    end

    assign prod_fix = sign_q ? -acc : acc;
    assign res_hi   = mode_div ? (sign_r ? -acc[63:32] : acc[63:32]) : prod_fix[63:32];
    assign res_lo   = mode_div ? (sign_q ? -acc[31:0]  : acc[31:0])  : prod_fix[31:0];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        stallreq   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stallreq   = 1'b1;
                    state_next = div_zero ? FINISH : RUN;
                end
            end
            RUN: begin
                stallreq = 1'b1;
                if (cnt == 5'd31) state_next = FINISH;
            end
            FINISH: begin
                stallreq   = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                if (!ex_hold) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Flush wins over everything except reset.
        if (cancel) begin
            state_next = IDLE;
            stallreq   = 1'b0;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // NOTE: only architecturally visible state is reset; acc/mcand/signs are
    // always loaded on accept before they are read, so they carry no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi  <= 32'd0;
            lo  <= 32'd0;
            cnt <= 5'd0;
        end else if (!cancel) begin
            case (state)
                IDLE: begin
                    if (op_valid && op_sel == OP_MTHI) hi <= src1;
                    if (op_valid && op_sel == OP_MTLO) lo <= src1;
                    if (accept) begin
                        cnt      <= 5'd0;
                        mode_div <= div_op;
                        if (div_zero) begin
                            // Fixed result: HI=dividend, LO=all ones, no sign fix.
                            acc    <= {src1, 32'hFFFF_FFFF};
                            mcand  <= abs2;
                            sign_q <= 1'b0;
                            sign_r <= 1'b0;
                        end else begin
                            acc    <= {32'd0, div_op ? abs1 : abs2};
                            mcand  <= div_op ? abs2 : abs1;
                            sign_q <= signed_op && (src1[31] ^ src2[31]);
                            sign_r <= signed_op && src1[31];
                        end
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 5'd1;
                end
                FINISH: begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
                default: ;
            endcase
        end else begin
            cnt <= 5'd0;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: table of mul/div vectors plus
// hand-written cancel, hold, reset and mthi/mtlo sequences.
module tb_hilo_muldiv_ctrl;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic        clk = 1'b0;
    logic        rst, op_valid, ex_hold, cancel;
    logic [2:0]  op_sel;
    logic [31:0] src1, src2;
    logic        stallreq, busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          stall;
    } vec_t;

    vec_t vecs[9];

    hilo_muldiv_ctrl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_sel(op_sel),
        .src1(src1), .src2(src2), .ex_hold(ex_hold), .cancel(cancel),
        .stallreq(stallreq), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        op_valid = 1'b1;
        op_sel   = op;
        src1     = a;
        src2     = b;
    endtask

    // Counts stalled cycles from the accept cycle; ends at the first DONE cycle.
    task automatic wait_done(input int exp_stall, input string tag);
        int n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stallreq) break;
            n++;
        end
        check({tag, " stall_cycles"}, n, exp_stall);
        check({tag, " done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        issue(v.op, v.a, v.b);
        wait_done(v.stall, tag);
        check({tag, " hi"}, hi, v.exp_hi);
        check({tag, " lo"}, lo, v.exp_lo);
        @(posedge clk); #1;
        op_valid = 1'b0;
        op_sel   = OP_NONE;
        @(negedge clk);
        check({tag, " idle_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34};
        vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 34};
        vecs[2] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 34};
        vecs[3] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
        vecs[4] = '{OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         34};
        vecs[5] = '{OP_DIVU,  32'h1234,      32'd0,         32'h1234,      32'hFFFF_FFFF, 2};
        vecs[6] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 34};
        vecs[7] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        34};
        vecs[8] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         34};

        rst = 1'b1; op_valid = 1'b0; op_sel = OP_NONE; src1 = '0; src2 = '0;
        ex_hold = 1'b0; cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset stallreq", {31'd0, stallreq}, 32'd0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Preload HI/LO, then show a cancelled mthi does not write.
        issue(OP_MTHI, 32'hAAAA_AAAA, 32'd0);
        @(negedge clk);
        check("mthi stallreq", {31'd0, stallreq}, 32'd0);
        issue(OP_MTLO, 32'h5555_5555, 32'd0);
        @(negedge clk);
        check("mthi hi", hi, 32'hAAAA_AAAA);
        issue(OP_MTHI, 32'h1234_5678, 32'd0);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0; op_valid = 1'b0;
        @(negedge clk);
        check("mtlo lo", lo, 32'h5555_5555);
        check("cancel mthi hi", hi, 32'hAAAA_AAAA);

        // Cancel a multiply in the RUN cycle with counter=10.
        issue(OP_MULT, 32'd1234, 32'd5678);
        repeat (11) @(posedge clk);
        #1 cancel = 1'b1;
        @(negedge clk);
        check("cancel stallreq", {31'd0, stallreq}, 32'd0);
        check("cancel busy_run", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        cancel = 1'b0; op_valid = 1'b0; op_sel = OP_NONE;
        @(negedge clk);
        check("cancel busy", {31'd0, busy}, 32'd0);
        check("cancel stall_after", {31'd0, stallreq}, 32'd0);
        check("cancel hi", hi, 32'hAAAA_AAAA);
        check("cancel lo", lo, 32'h5555_5555);

        // Divide completing under ex_hold with op_valid still asserted.
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(34, "hold");
        ex_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("hold%0d done", k), {31'd0, done}, 32'd1);
            check($sformatf("hold%0d stallreq", k), {31'd0, stallreq}, 32'd0);
            check($sformatf("hold%0d hi", k), hi, 32'hFFFF_FFFF);
            check($sformatf("hold%0d lo", k), lo, 32'hFFFF_FFFD);
        end
        @(posedge clk); #1 ex_hold = 1'b0;
        @(negedge clk);
        check("hold last done", {31'd0, done}, 32'd1);
        run_vec('{OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 34}, "b2b");

        // Reset mid-RUN.
        issue(OP_MULT, 32'd7, 32'd9);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; op_valid = 1'b0; op_sel = OP_NONE;
        @(negedge clk);
        check("midrst hi", hi, 32'd0);
        check("midrst lo", lo, 32'd0);
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst stallreq", {31'd0, stallreq}, 32'd0);

        // mthi held for four cycles.
        issue(OP_MTHI, 32'd1, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("mthi_hold%0d stallreq", k), {31'd0, stallreq}, 32'd0);
            check($sformatf("mthi_hold%0d busy", k), {31'd0, busy}, 32'd0);
            if (k < 3) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1 op_valid = 1'b0;
        @(negedge clk);
        check("mthi_hold hi", hi, 32'd1);
        check("mthi_hold lo", lo, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
